// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: lock supervisor and loop-filter profile sequencer for the
// system PLL dynamic-configuration port. Walks a 4-entry table of
// charge-pump / loop-filter settings until the PLL holds lock, then releases
// the downstream reset. Re-acquires on lock loss and counts those events.
module pll_lock_ctrl #(
  parameter int          RST_CYCLES    = 64,
  parameter int          LOCK_TIMEOUT  = 65536,
  parameter int          STABLE_CYCLES = 4096,
  parameter logic [10:0] PROFILE0      = 11'h2A0,
  parameter logic [10:0] PROFILE1      = 11'h330,
  parameter logic [10:0] PROFILE2      = 11'h1C4,
  parameter logic [10:0] PROFILE3      = 11'h3F9
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_pll_lock,
  output logic       o_pll_reset,
  output logic [5:0] o_icpsel,
  output logic [2:0] o_lpfres,
  output logic [1:0] o_lpfcap,
  output logic       o_ready,
  output logic       o_sys_reset,
  output logic       o_fail,
  output logic [1:0] o_profile,
  output logic [7:0] o_relock_count
);

  // One shared counter covers the longest of the three phases.
  localparam int MAX_AB = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int MAXC   = (MAX_AB > RST_CYCLES) ? MAX_AB : RST_CYCLES;
  localparam int CW     = (MAXC > 2) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_LOCKED,
    S_FAIL
  } state_t;

  // Profile word layout is {icp[5:0], res[2:0], cap[1:0]}.
  function automatic logic [10:0] prof_word(input logic [1:0] idx);
    logic [10:0] w;
    case (idx)
      2'd0:    w = PROFILE0;
      2'd1:    w = PROFILE1;
      2'd2:    w = PROFILE2;
      default: w = PROFILE3;
    endcase
    return w;
  endfunction

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_sync1;
  logic          r_lock_s;
  logic [1:0]    r_profile;
  logic [7:0]    r_relock;
  logic          r_pll_reset;
  logic [10:0]   r_cfg;
  logic          r_ready;
  logic          r_sys_reset;
  logic          r_fail;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_profile_nxt;
  logic [7:0]    w_relock_nxt;
  logic          w_attempt_fail;
  logic          w_load_cfg;
  logic          w_stay_locked;

  // Two-flop synchronizer: pll_lock is asynchronous to the reference clock.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= i_pll_lock;
      r_lock_s <= r_sync1;
    end
  end

  // Next-state logic; start overrides everything, then lock loss/timeout.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_profile_nxt  = r_profile;
    w_relock_nxt   = r_relock;
    w_attempt_fail = 1'b0;
    if (i_start) begin
      w_state_nxt   = S_RESET_PLL;
      w_cnt_nxt     = '0;
      w_profile_nxt = 2'd0;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_cnt == RST_LAST) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (r_lock_s) begin
            w_state_nxt = S_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == TMO_LAST) begin
            w_attempt_fail = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_STABLE: begin
          if (!r_lock_s) begin
            w_attempt_fail = 1'b1;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_nxt = S_LOCKED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_LOCKED: begin
          // Lock loss: retry with the profile that worked last time.
          if (!r_lock_s) begin
            w_state_nxt = S_RESET_PLL;
            w_cnt_nxt   = '0;
            if (r_relock != 8'hFF) w_relock_nxt = r_relock + 8'd1;
          end
        end
        S_FAIL: begin
          w_state_nxt = S_FAIL;
        end
        default: begin
          w_state_nxt = S_RESET_PLL;
          w_cnt_nxt   = '0;
        end
      endcase
      if (w_attempt_fail) begin
        w_cnt_nxt = '0;
        if (r_profile == 2'd3) begin
          w_state_nxt = S_FAIL;
        end else begin
          w_state_nxt   = S_RESET_PLL;
          w_profile_nxt = r_profile + 2'd1;
        end
      end
    end
  end

  // Config is only reloaded on the edge that enters RESET_PLL (incl. restart),
  // so the PLL never sees a profile change while it is out of reset.
  assign w_load_cfg    = (w_state_nxt == S_RESET_PLL) && (i_start || (r_state != S_RESET_PLL));
  // ready follows LOCKED one edge late on entry, but drops on the exit edge.
  assign w_stay_locked = (r_state == S_LOCKED) && (w_state_nxt == S_LOCKED);

  // FSM state register, shared counter, profile index and relock counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_RESET_PLL;
      r_cnt     <= '0;
      r_profile <= 2'd0;
      r_relock  <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_profile <= w_profile_nxt;
      r_relock  <= w_relock_nxt;
    end
  end

  // Registered outputs, derived from the upcoming state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pll_reset <= 1'b1;
      r_cfg       <= PROFILE0;
      r_ready     <= 1'b0;
      r_sys_reset <= 1'b1;
      r_fail      <= 1'b0;
    end else begin
      r_pll_reset <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAIL);
      r_ready     <= w_stay_locked;
      r_sys_reset <= !w_stay_locked;
      r_fail      <= (w_state_nxt == S_FAIL);
      if (w_load_cfg) r_cfg <= prof_word(w_profile_nxt);
    end
  end

  assign o_pll_reset    = r_pll_reset;
  assign o_icpsel       = r_cfg[10:5];
  assign o_lpfres       = r_cfg[4:2];
  assign o_lpfcap       = r_cfg[1:0];
  assign o_ready        = r_ready;
  assign o_sys_reset    = r_sys_reset;
  assign o_fail         = r_fail;
  assign o_profile      = r_profile;
  assign o_relock_count = r_relock;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: directed scenarios plus random lock/start traffic,
// every cycle compared against a phase/elapsed-edge reference model.
module tb_pll_lock_ctrl;

  localparam int RSTC = 4;
  localparam int TO   = 20;
  localparam int STC  = 8;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_LOCK = 3;
  localparam int P_FAIL = 4;

  logic       clk = 1'b0;
  logic       i_reset, i_start, i_pll_lock;
  logic       o_pll_reset, o_ready, o_sys_reset, o_fail;
  logic [5:0] o_icpsel;
  logic [2:0] o_lpfres;
  logic [1:0] o_lpfcap, o_profile;
  logic [7:0] o_relock_count;

  int nchk = 0;
  int nerr = 0;

  // model: phase, edges spent in phase, profile, relock events, lock history
  int          m_phase, m_n, m_prof, m_rel;
  logic        m_h0, m_h1;
  logic [10:0] prev_cfg = '0;

  pll_lock_ctrl #(.RST_CYCLES(RSTC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(STC)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_pll_lock(i_pll_lock),
    .o_pll_reset(o_pll_reset), .o_icpsel(o_icpsel), .o_lpfres(o_lpfres),
    .o_lpfcap(o_lpfcap), .o_ready(o_ready), .o_sys_reset(o_sys_reset),
    .o_fail(o_fail), .o_profile(o_profile), .o_relock_count(o_relock_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] prof_word(input int i);
    case (i)
      0:       return 11'h2A0;
      1:       return 11'h330;
      2:       return 11'h1C4;
      default: return 11'h3F9;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_RST; m_n = 0; m_prof = 0; m_rel = 0; m_h0 = 1'b0; m_h1 = 1'b0;
  endtask

  task automatic attempt_failed();
    if (m_prof == 3) m_phase = P_FAIL;
    else begin m_prof++; m_phase = P_RST; end
    m_n = 0;
  endtask

  // One clock edge of the specified behaviour; ls is pll_lock from two edges ago.
  task automatic model_step(input logic st, input logic lk);
    logic ls;
    ls = m_h1; m_h1 = m_h0; m_h0 = lk;
    if (st) begin
      m_phase = P_RST; m_n = 0; m_prof = 0;
    end else begin
      case (m_phase)
        P_RST: begin
          m_n++;
          if (m_n == RSTC) begin m_phase = P_WAIT; m_n = 0; end
        end
        P_WAIT: begin
          if (ls) begin m_phase = P_STAB; m_n = 0; end
          else begin m_n++; if (m_n == TO) attempt_failed(); end
        end
        P_STAB: begin
          if (!ls) attempt_failed();
          else begin
            m_n++;
            if (m_n == STC) begin m_phase = P_LOCK; m_n = 0; end
          end
        end
        P_LOCK: begin
          if (!ls) begin
            if (m_rel < 255) m_rel++;
            m_phase = P_RST; m_n = 0;
          end else m_n = 1;
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic exp_ready();
    return (m_phase == P_LOCK) && (m_n >= 1);
  endfunction

  task automatic check_all();
    logic [10:0] cfg;
    cfg = {o_icpsel, o_lpfres, o_lpfcap};
    chk("pll_reset", o_pll_reset, (m_phase == P_RST) || (m_phase == P_FAIL));
    chk("ready", o_ready, exp_ready());
    chk("sys_reset", o_sys_reset, !exp_ready());
    chk("fail", o_fail, m_phase == P_FAIL);
    chk("profile", o_profile, m_prof);
    chk("relock_count", o_relock_count, m_rel);
    chk("cfg", cfg, prof_word(m_prof));
    if (cfg !== prev_cfg) chk("cfg_change_needs_pll_reset", o_pll_reset, 1);
    prev_cfg = cfg;
  endtask

  task automatic cyc(input logic st, input logic lk);
    i_start = st; i_pll_lock = lk;
    @(posedge clk);
    model_step(st, lk);
    #1;
    check_all();
  endtask

  task automatic run_until_ready(input int maxc);
    int k;
    k = 0;
    while (!exp_ready() && k < maxc) begin cyc(1'b0, 1'b1); k++; end
    chk("reach_ready", o_ready, 1);
  endtask

  task automatic run_until_phase(input int ph, input int n, input logic lk, input int maxc);
    int k;
    k = 0;
    while (!(m_phase == ph && m_n == n) && k < maxc) begin cyc(1'b0, lk); k++; end
    nchk++;
    assert (k < maxc) else begin
      nerr++;
      $error("FAIL wait_phase: got %0d cycles expected below %0d", k, maxc);
    end
  endtask

  initial begin
    int fall, rise, fedge;
    logic any_ready, lk;

    i_reset = 1'b1; i_start = 1'b0; i_pll_lock = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
    model_reset();
    check_all();
    chk("reset_icpsel", o_icpsel, 6'h15);
    chk("reset_lpfres", o_lpfres, 3'h0);
    chk("reset_lpfcap", o_lpfcap, 2'h0);

    // lock tied high: pll_reset falls at edge 4, WAIT sees lock at 5, ready at 5+8+1
    fall = 0; rise = 0;
    for (int e = 1; e <= 20; e++) begin
      cyc(1'b0, 1'b1);
      if (fall == 0 && o_pll_reset === 1'b0) fall = e;
      if (rise == 0 && o_ready === 1'b1) rise = e;
    end
    chk("pll_reset_fall_edge", fall, 4);
    chk("ready_rise_edge", rise, 14);
    chk("locked_profile", o_profile, 0);

    // lock held low: four attempts of 4+20 edges, then FAIL
    cyc(1'b1, 1'b0);
    fedge = 0;
    for (int e = 1; e <= 100; e++) begin
      cyc(1'b0, 1'b0);
      if (fedge == 0 && o_fail === 1'b1) fedge = e;
    end
    chk("fail_edge", fedge, 96);
    chk("fail_flag", o_fail, 1);
    chk("fail_pll_reset", o_pll_reset, 1);
    chk("fail_profile", o_profile, 3);
    cyc(1'b1, 1'b0);
    chk("restart_profile", o_profile, 0);
    chk("restart_fail", o_fail, 0);

    // 3-cycle lock glitch during STABLE on profile 0
    run_until_phase(P_STAB, 2, 1'b1, 40);
    any_ready = 1'b0;
    repeat (3) begin cyc(1'b0, 1'b0); any_ready |= o_ready; end
    chk("glitch_profile", o_profile, 1);
    chk("glitch_pll_reset", o_pll_reset, 1);
    chk("glitch_no_ready", any_ready, 0);
    chk("glitch_icpsel", o_icpsel, 6'h19);

    // repeated 5-cycle lock drops while LOCKED
    for (int i = 0; i < 300; i++) begin
      run_until_ready(60);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      if (i == 0) chk("drop_ready_still_high", o_ready, 1);
      cyc(1'b0, 1'b0);
      if (i == 0) begin
        chk("drop_ready_low", o_ready, 0);
        chk("drop_pll_reset", o_pll_reset, 1);
        chk("drop_relock1", o_relock_count, 1);
        chk("drop_same_profile", o_profile, 1);
      end
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
    end
    run_until_ready(60);
    chk("relock_saturated", o_relock_count, 255);
    chk("relock_profile", o_profile, 1);

    // reach LOCKED on profile 2, then restart
    cyc(1'b1, 1'b0);
    repeat (48) cyc(1'b0, 1'b0);
    chk("reach_profile2", o_profile, 2);
    run_until_ready(60);
    chk("locked_on_p2", o_profile, 2);
    cyc(1'b1, 1'b1);
    chk("start_ready", o_ready, 0);
    chk("start_pll_reset", o_pll_reset, 1);
    chk("start_profile", o_profile, 0);
    chk("start_keeps_relock", o_relock_count, 255);

    // random traffic: sticky lock with occasional flips, rare starts
    lk = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(15) == 0) lk = ~lk;
      cyc($urandom_range(199) == 0, lk);
    end

    // async reset in the middle of WAIT_LOCK
    cyc(1'b1, 1'b0);
    run_until_phase(P_WAIT, 5, 1'b0, 30);
    #3 i_reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("areset_pll_reset", o_pll_reset, 1);
    chk("areset_ready", o_ready, 0);
    chk("areset_profile", o_profile, 0);
    chk("areset_relock", o_relock_count, 0);
    chk("areset_icpsel", o_icpsel, 6'h15);
    @(posedge clk);
    #1 i_reset = 1'b0;

    lk = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(31) == 0) lk = ~lk;
      cyc($urandom_range(299) == 0, lk);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
